multi_debounce: RTL and testbench
=================================

Name: multi_debounce

Overview:
Parametrised multi-channel push-button debouncer. It replaces the single-channel, fixed-period debouncer in the FSM lab designs. Each channel has an input synchronizer, a shared sample-tick generator, a configurable stable-sample count, one-cycle rise/fall event pulses and an optional long-press detector. It sits between raw board buttons/switches and the downstream control FSMs.

Parameters:
CH, 4, number of independent button channels (>=1)
TICK_W, 13, width of the shared tick counter; tick period P = 2^TICK_W clk cycles
STABLE, 3, consecutive ticks of a stable level required to change db (>=1)
SYNC_STAGES, 2, flip-flop stages in each input synchronizer (>=2)
LONG_TICKS, 64, ticks held in ONE before long_press fires (>=1; used only with the macro)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
btn  input  CH  raw asynchronous button inputs, active-high
db  output  CH  debounced level per channel
rise  output  CH  one-cycle pulse when db goes 0->1
fall  output  CH  one-cycle pulse when db goes 1->0
tick  output  1  shared sample tick, one cycle wide, period P
long_press  output  CH  one-cycle long-press pulse; constant 0 when the feature is compiled out

Behaviour:
- Clocking and reset: clk is the only clock. reset is asynchronous, active-high. On reset:
  - all synchronizer flops, tick counter, per-channel states and stability counters clear to 0
  - db, rise, fall, tick and long_press are 0
- Synchronizer: btn[i] passes through SYNC_STAGES flops. s[i] is the last stage. Logic beyond the synchronizer uses only s[i].
- Tick counter:
  - TICK_W-bit free-running up-counter that wraps.
  - tick = 1 when the counter is all ones, so the first tick comes P-1 cycles after reset release.
  - The counter is shared by all channels.
- Per-channel FSM: states ZERO, WAIT1, ONE, WAIT0. Each channel has a stability counter cnt of width clog2(STABLE+1).
  - ZERO: if s=1, go to WAIT1 with cnt=0.
  - WAIT1: if s=0, go to ZERO (abort). Otherwise, on tick: if cnt==STABLE-1, go to ONE; else cnt++.
  - ONE: if s=0, go to WAIT0 with cnt=0.
  - WAIT0: if s=1, go to ONE (abort). Otherwise, on tick: if cnt==STABLE-1, go to ZERO; else cnt++.
  - Illegal or unused encodings go to ZERO.
- Outputs (all registered, so they change on the same edge as the state):
  - db = 1 in ONE and WAIT0; 0 in ZERO and WAIT1.
  - rise pulses for one cycle in the cycle after the WAIT1->ONE transition edge, coincident with db rising.
  - fall pulses likewise on WAIT0->ZERO.
  - rise and fall are never asserted together on one channel.
- Latency: a clean edge on btn propagates to db within SYNC_STAGES + (STABLE-1)*P + 1 to SYNC_STAGES + STABLE*P + 1 cycles. The exact value depends on tick phase.
- Simultaneous events:
  - If the input changes in the same cycle as tick, the abort wins and cnt is not incremented.
  - Channels are fully independent. Several channels may pulse in the same cycle.
- STABLE=1: the transition happens on the first tick observed in WAIT1/WAIT0.
- Reset mid-operation: any channel in WAIT1/ONE/WAIT0 returns to ZERO. No rise/fall pulse is generated by the reset itself.

Optional Feature:
- Macro: MULTI_DEBOUNCE_LONGPRESS_EN.
- When defined, each channel gets a long counter of width clog2(LONG_TICKS+1):
  - increments on tick while in ONE
  - holds its value in WAIT0
  - clears in ZERO/WAIT1
  - saturates at LONG_TICKS
  - long_press[i] pulses for one cycle on the tick where the counter reaches LONG_TICKS, so it fires once per press
  - a bounce WAIT0->ONE does not re-fire it
- When not defined, no long counters are built and long_press is tied to 0.

Test Plan:
Bench parameters: CH=2, TICK_W=3 (P=8), STABLE=3, SYNC_STAGES=2, LONG_TICKS=4.
1. Reset: assert reset for 3 cycles with btn=2'b11, then release -> all outputs 0 during reset; first tick pulse 7 cycles after release.
2. Clean press: btn[0] rises and is held 40 cycles -> db[0] rises between 2+16+1 and 2+24+1 cycles after the edge; rise[0] pulses for exactly 1 cycle, coincident with db[0] rising; ch1 outputs stay 0.
3. Bounce: btn[0] toggles every 5 cycles for 60 cycles -> db[0] stays 0; no rise or fall pulse.
4. Release glitch: with db[0]=1, drive btn[0]=0 for 10 cycles, then 1 -> db[0] stays 1; no fall pulse. A later sustained release gives fall[0] for exactly 1 cycle, then db[0]=0.
5. Simultaneous activity and reset:
   - both btn bits rise in the same cycle -> rise=2'b11 in one cycle
   - assert reset while ch0 is in WAIT1 -> db=0; no pulses; FSM back in ZERO
6. Long press, with the macro defined: hold btn[0] for 4 ticks after db[0]=1 -> long_press[0] pulses once. Then release for 1 tick and press again -> no second pulse. Without the macro, long_press stays 0 throughout.

Source files
------------

// File: rtl/multi_debounce.sv
`timescale 1ns/1ps
// multi_debounce: multi-channel push-button debouncer.
// Each channel has a SYNC_STAGES-deep synchronizer and a 4-state
// stability FSM (ZERO/WAIT1/ONE/WAIT0). The FSM samples on a tick shared by
// all channels, with period 2^TICK_W. db, rise and fall are registered.
// Optional long-press detector: define MULTI_DEBOUNCE_LONGPRESS_EN to build
// it. Without it, long_press is tied to 0.
module multi_debounce #(
   parameter int CH          = 4,
   parameter int TICK_W      = 13,
   parameter int STABLE      = 3,
   parameter int SYNC_STAGES = 2,
   parameter int LONG_TICKS  = 64
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [CH-1:0] btn,
   output logic [CH-1:0] db,
   output logic [CH-1:0] rise,
   output logic [CH-1:0] fall,
   output logic          tick,
   output logic [CH-1:0] long_press
);

   localparam int CNT_W = $clog2(STABLE + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE - 1);

   typedef enum logic [1:0] {
      ZERO  = 2'd0,
      WAIT1 = 2'd1,
      ONE   = 2'd2,
      WAIT0 = 2'd3
   } state_t;

   // Parameter sanity checks, evaluated at elaboration time.
   if (CH < 1)          begin : g_bad_ch     $error("CH must be >= 1");          end
   if (STABLE < 1)      begin : g_bad_stable $error("STABLE must be >= 1");      end
   if (SYNC_STAGES < 2) begin : g_bad_sync   $error("SYNC_STAGES must be >= 2"); end
   if (LONG_TICKS < 1)  begin : g_bad_long   $error("LONG_TICKS must be >= 1");  end

   logic [TICK_W-1:0] tick_cnt_reg;

   // Free-running tick counter shared by every channel. It wraps naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) tick_cnt_reg <= '0;
      else       tick_cnt_reg <= tick_cnt_reg + 1'b1;
   end

   // Tick is asserted while the counter is all ones. The first tick
   // therefore comes P-1 cycles after reset is released.
   assign tick = &tick_cnt_reg;

   for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   s;
      state_t                 state_reg;
      logic [CNT_W-1:0]       cnt_reg;
      logic                   db_reg;
      logic                   rise_reg;
      logic                   fall_reg;

      // Input synchronizer; only the last stage feeds the FSM.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) sync_reg <= '0;
         else       sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn[gi]};
      end

      assign s = sync_reg[SYNC_STAGES-1];

      // Stability FSM. An input change always aborts a pending transition,
      // even when it lands on a tick. The outputs are registered together
      // with the state.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            state_reg <= ZERO;
            cnt_reg   <= '0;
            db_reg    <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
         end else begin
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
            case (state_reg)
               ZERO: begin
                  if (s) begin
                     state_reg <= WAIT1;
                     cnt_reg   <= '0;
                  end
               end
               WAIT1: begin
                  if (!s) begin
                     state_reg <= ZERO;
                  end else if (tick) begin
                     if (cnt_reg == CNT_LAST) begin
                        state_reg <= ONE;
                        db_reg    <= 1'b1;
                        rise_reg  <= 1'b1;
                     end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                     end
                  end
               end
               ONE: begin
                  if (!s) begin
                     state_reg <= WAIT0;
                     cnt_reg   <= '0;
                  end
               end
               WAIT0: begin
                  if (s) begin
                     state_reg <= ONE;
                  end else if (tick) begin
                     if (cnt_reg == CNT_LAST) begin
                        state_reg <= ZERO;
                        db_reg    <= 1'b0;
                        fall_reg  <= 1'b1;
                     end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                     end
                  end
               end
               default: begin
                  state_reg <= ZERO;
                  db_reg    <= 1'b0;
               end
            endcase
         end
      end

      assign db[gi]   = db_reg;
      assign rise[gi] = rise_reg;
      assign fall[gi] = fall_reg;

`ifdef MULTI_DEBOUNCE_LONGPRESS_EN
      localparam int LONG_W = $clog2(LONG_TICKS + 1);
      localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_TICKS);
      localparam logic [LONG_W-1:0] LONG_PRE = LONG_W'(LONG_TICKS - 1);

      logic [LONG_W-1:0] long_cnt_reg;
      logic              long_reg;

      // Long-press counter. It counts ticks spent in ONE and holds across a
      // brief WAIT0 bounce, so it fires only once per press. It saturates at
      // LONG_TICKS.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            long_cnt_reg <= '0;
            long_reg     <= 1'b0;
         end else begin
            long_reg <= 1'b0;
            case (state_reg)
               ONE: begin
                  if (tick && (long_cnt_reg != LONG_MAX)) begin
                     long_cnt_reg <= long_cnt_reg + 1'b1;
                     if (long_cnt_reg == LONG_PRE) long_reg <= 1'b1;
                  end
               end
               WAIT0:   long_cnt_reg <= long_cnt_reg;
               default: long_cnt_reg <= '0;
            endcase
         end
      end

      assign long_press[gi] = long_reg;
`else
      assign long_press[gi] = 1'b0;
`endif
   end

endmodule

// File: tb/tb_multi_debounce.sv
`timescale 1ns/1ps
// tb_multi_debounce: scoreboard bench for multi_debounce (CH=2, P=8,
// STABLE=3, SYNC_STAGES=2, LONG_TICKS=4).
// The driver applies one input vector per negedge and advances a reference
// model, then queues the expected outputs. A monitor compares those outputs
// with the DUT 1 ns after each posedge.
module tb_multi_debounce;
   localparam int CH          = 2;
   localparam int TICK_W      = 3;
   localparam int STABLE      = 3;
   localparam int SYNC_STAGES = 2;
   localparam int LONG_TICKS  = 4;
   localparam int P           = 1 << TICK_W;
`ifdef MULTI_DEBOUNCE_LONGPRESS_EN
   localparam bit LONG_EN = 1'b1;
`else
   localparam bit LONG_EN = 1'b0;
`endif

   logic          clk   = 1'b0;
   logic          reset = 1'b1;
   logic [CH-1:0] btn   = '0;
   logic [CH-1:0] db, rise, fall, long_press;
   logic          tick;

   multi_debounce #(
      .CH(CH), .TICK_W(TICK_W), .STABLE(STABLE),
      .SYNC_STAGES(SYNC_STAGES), .LONG_TICKS(LONG_TICKS)
   ) dut (
      .clk(clk), .reset(reset), .btn(btn), .db(db), .rise(rise),
      .fall(fall), .tick(tick), .long_press(long_press)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [CH-1:0] db;
      logic [CH-1:0] rise;
      logic [CH-1:0] fall;
      logic [CH-1:0] lp;
      logic          tick;
   } exp_t;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   cycle_no    = 0;

   // Reference model state. Per channel it tracks the accepted level, a
   // "change pending" flag, the number of ticks the input has held the
   // other level, and the ticks spent pressed.
   bit m_sync [CH][SYNC_STAGES];
   int m_tcnt;
   bit m_db   [CH];
   bit m_pend [CH];
   int m_k    [CH];
   int m_lc   [CH];

   task automatic model_step(input logic [CH-1:0] b, input logic r);
      exp_t e;
      bit   tick_now;
      bit   s;
      e = '0;
      if (r) begin
         m_tcnt = 0;
         for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < SYNC_STAGES; k++) m_sync[c][k] = 1'b0;
            m_db[c] = 1'b0; m_pend[c] = 1'b0; m_k[c] = 0; m_lc[c] = 0;
         end
      end else begin
         tick_now = (m_tcnt == P - 1);
         for (int c = 0; c < CH; c++) begin
            s = m_sync[c][SYNC_STAGES-1];
            if (LONG_EN) begin
               if (m_db[c] && !m_pend[c]) begin
                  if (tick_now && m_lc[c] < LONG_TICKS) begin
                     m_lc[c]++;
                     if (m_lc[c] == LONG_TICKS) e.lp[c] = 1'b1;
                  end
               end else if (!m_db[c]) begin
                  m_lc[c] = 0;
               end
            end
            if (s == m_db[c]) begin
               m_pend[c] = 1'b0;
            end else if (!m_pend[c]) begin
               m_pend[c] = 1'b1;
               m_k[c]    = 0;
            end else if (tick_now) begin
               m_k[c]++;
               if (m_k[c] == STABLE) begin
                  m_db[c]   = !m_db[c];
                  m_pend[c] = 1'b0;
                  if (m_db[c]) e.rise[c] = 1'b1;
                  else         e.fall[c] = 1'b1;
               end
            end
            e.db[c] = m_db[c];
            for (int k = SYNC_STAGES - 1; k > 0; k--) m_sync[c][k] = m_sync[c][k-1];
            m_sync[c][0] = b[c];
         end
         m_tcnt = (m_tcnt + 1) % P;
         e.tick = (m_tcnt == P - 1);
      end
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic [CH-1:0] b, input logic r, input int n);
      repeat (n) begin
         @(negedge clk);
         btn   = b;
         reset = r;
         model_step(b, r);
      end
   endtask

   task automatic report(input string name);
      $display("phase %-12s done at cycle %0d: %0d vectors, %0d miscompares",
               name, cycle_no, vectors, miscompares);
   endtask

   // Monitor: compare the DUT against the oldest queued expectation after each edge.
   always @(posedge clk) begin
      exp_t e;
      exp_t a;
      cycle_no++;
      #1;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         a.db = db; a.rise = rise; a.fall = fall; a.lp = long_press; a.tick = tick;
         vectors++;
         if (a !== e) begin
            miscompares++;
            $display("FAIL outputs cycle %0d: got db=%b rise=%b fall=%b lp=%b tick=%b, want db=%b rise=%b fall=%b lp=%b tick=%b",
                     cycle_no, a.db, a.rise, a.fall, a.lp, a.tick,
                     e.db, e.rise, e.fall, e.lp, e.tick);
         end
      end
   end

   initial begin
      int            rem [CH];
      logic [CH-1:0] rb;
      // 1. reset with buttons held, then release
      drive(2'b11, 1'b1, 3);
      drive(2'b00, 1'b0, 12);
      report("reset");
      // 2. clean press on channel 0
      drive(2'b01, 1'b0, 40);
      drive(2'b00, 1'b0, 40);
      report("press");
      // 3. bounce on channel 0
      for (int i = 0; i < 12; i++) drive((i % 2 == 0) ? 2'b01 : 2'b00, 1'b0, 5);
      drive(2'b00, 1'b0, 20);
      report("bounce");
      // 4. release glitch while pressed, then a real release
      drive(2'b01, 1'b0, 40);
      drive(2'b00, 1'b0, 10);
      drive(2'b01, 1'b0, 20);
      drive(2'b00, 1'b0, 40);
      report("glitch");
      // 5. both channels together, then reset while channel 0 is in WAIT1
      drive(2'b11, 1'b0, 40);
      drive(2'b00, 1'b0, 40);
      drive(2'b01, 1'b0, 10);
      drive(2'b01, 1'b1, 2);
      drive(2'b00, 1'b0, 20);
      report("simul_reset");
      // 6. long press, a short release, then a second press
      drive(2'b01, 1'b0, 80);
      drive(2'b00, 1'b0, 8);
      drive(2'b01, 1'b0, 40);
      drive(2'b00, 1'b0, 40);
      report("long_press");
      // 7. random run lengths per channel, with rare resets
      for (int c = 0; c < CH; c++) rem[c] = 0;
      rb = '0;
      for (int i = 0; i < 1000; i++) begin
         for (int c = 0; c < CH; c++) begin
            if (rem[c] == 0) begin
               rb[c]  = 1'($urandom_range(0, 1));
               rem[c] = $urandom_range(1, 40);
            end
            rem[c]--;
         end
         drive(rb, ($urandom_range(0, 399) == 0), 1);
      end
      report("random");
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
